// File: rtl/song_sequencer_if.sv
// Pattern-ROM fetch port of the song sequencer: request/address out, ack/trigger data back.
interface song_sequencer_if #(
  parameter int POS_W = 9
);
  logic             rom_req_o;
  logic [POS_W-1:0] rom_addr_o;
  logic             rom_ack_i;
  logic [1:0]       rom_data_i;

  modport master (output rom_req_o, rom_addr_o, input rom_ack_i, rom_data_i);
  modport slave  (input rom_req_o, rom_addr_o, output rom_ack_i, rom_data_i);
endinterface

// File: rtl/song_sequencer.sv
// Beat/tick scheduler: frame ticks -> beats -> song position, pattern fetch, envelope volumes.
// Optional swing timing (alternating long/short beats) is enabled by defining SEQ_SWING_EN.
//
// state | meaning
// IDLE  | counting frame ticks, decaying envelopes
// FETCH | rom_req_o held, waiting for rom_ack_i
// APPLY | one-cycle settle after the trigger bits were applied
module song_sequencer #(
  parameter int SONG_LEN       = 288,
  parameter int LOOP_START     = 0,
  parameter int TICKS_PER_BEAT = 6,
  parameter int POS_W          = 9,
  parameter int VOL_W          = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_i,
  input  logic              run_i,
  input  logic              restart_i,
  output logic [POS_W-1:0]  songpos_o,
  output logic              beat_o,
  output logic [VOL_W-1:0]  sqr_vol_o,
  output logic [VOL_W-1:0]  bass_vol_o,
  output logic              overrun_o,
  song_sequencer_if.master  rom
);

  localparam int CTR_W = $clog2(TICKS_PER_BEAT + 2);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(SONG_LEN - 1);
  localparam logic [POS_W-1:0] POS_LOOP = POS_W'(LOOP_START);
  localparam logic [VOL_W-1:0] VMAX     = {VOL_W{1'b1}};

  typedef enum logic [1:0] {IDLE, FETCH, APPLY} state_t;

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [VOL_W-1:0] sqr_q, sqr_d;
  logic [VOL_W-1:0] bass_q, bass_d;
  logic             beat_q, beat_d;
  logic             req_q, req_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;

  logic [CTR_W-1:0] beat_len;
  logic [CTR_W-1:0] ctr_next;

`ifdef SEQ_SWING_EN
  // Even positions get the long beat, odd ones the short beat; the pair keeps the tempo.
  assign beat_len = pos_q[0] ? CTR_W'(TICKS_PER_BEAT - 1) : CTR_W'(TICKS_PER_BEAT + 1);
`else
  assign beat_len = CTR_W'(TICKS_PER_BEAT);
`endif

  assign ctr_next = ctr_q + CTR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctr_q     <= '0;
      pos_q     <= POS_LAST;
      sqr_q     <= '0;
      bass_q    <= '0;
      beat_q    <= 1'b0;
      req_q     <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      pos_q     <= pos_d;
      sqr_q     <= sqr_d;
      bass_q    <= bass_d;
      beat_q    <= beat_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    pos_d     = pos_q;
    sqr_d     = sqr_q;
    bass_d    = bass_q;
    beat_d    = 1'b0;
    req_d     = req_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    if (restart_i) begin
      state_d   = IDLE;
      ctr_d     = '0;
      pos_d     = POS_LAST;
      sqr_d     = '0;
      bass_d    = '0;
      req_d     = 1'b0;
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end else begin
      // Ticks that arrive mid-fetch are deferred once; a second one is lost.
      if (state_q != IDLE && tick_i && run_i) begin
        if (pending_q) overrun_d = 1'b1;
        else           pending_d = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (run_i && (tick_i || pending_q)) begin
            // Serving a deferred tick while a fresh one arrives re-arms pending.
            pending_d = pending_q & tick_i;
            if (ctr_next == beat_len) begin
              ctr_d   = '0;
              pos_d   = (pos_q == POS_LAST) ? POS_LOOP : pos_q + POS_W'(1);
              beat_d  = 1'b1;
              req_d   = 1'b1;
              state_d = FETCH;
            end else begin
              ctr_d  = ctr_next;
              sqr_d  = sqr_q - (sqr_q >> 3);
              bass_d = bass_q - (bass_q >> 2);
            end
          end
        end
        FETCH: begin
          if (rom.rom_ack_i) begin
            req_d   = 1'b0;
            state_d = APPLY;
            if (rom.rom_data_i[1]) sqr_d  = VMAX;
            if (rom.rom_data_i[0]) bass_d = VMAX;
          end
        end
        APPLY: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign songpos_o      = pos_q;
  assign beat_o         = beat_q;
  assign sqr_vol_o      = sqr_q;
  assign bass_vol_o     = bass_q;
  assign overrun_o      = overrun_q;
  assign rom.rom_req_o  = req_q;
  assign rom.rom_addr_o = pos_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a reference model pushes expected
// position/volume/beat values to a scoreboard that is popped when the DUT is sampled.
module tb_song_sequencer;
  localparam int POS_W    = 9;
  localparam int VOL_W    = 6;
  localparam int SONG_LEN = 288;
  localparam int TPB      = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_i = 1'b0;
  logic run_i = 1'b0;
  logic restart_i = 1'b0;
  logic [POS_W-1:0] songpos_o;
  logic beat_o;
  logic [VOL_W-1:0] sqr_vol_o;
  logic [VOL_W-1:0] bass_vol_o;
  logic overrun_o;

  song_sequencer_if #(.POS_W(POS_W)) rom_if ();

  song_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_i),
    .run_i      (run_i),
    .restart_i  (restart_i),
    .songpos_o  (songpos_o),
    .beat_o     (beat_o),
    .sqr_vol_o  (sqr_vol_o),
    .bass_vol_o (bass_vol_o),
    .overrun_o  (overrun_o),
    .rom        (rom_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [VOL_W-1:0] sqr;
    logic [VOL_W-1:0] bass;
    logic             beat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ctr, m_pos, m_sqr, m_bass;

  function automatic int beat_len(int pos);
`ifdef SEQ_SWING_EN
    return (pos % 2 == 0) ? TPB + 1 : TPB - 1;
`else
    return TPB;
`endif
  endfunction

  function void push_exp(bit beat);
    exp_t e;
    e.pos  = POS_W'(m_pos);
    e.sqr  = VOL_W'(m_sqr);
    e.bass = VOL_W'(m_bass);
    e.beat = beat;
    sb.push_back(e);
  endfunction

  function void model_reset();
    m_ctr = 0; m_pos = SONG_LEN - 1; m_sqr = 0; m_bass = 0;
    push_exp(1'b0);
  endfunction

  // One processed tick; returns 1 when it completes a beat.
  function bit model_tick();
    m_ctr = m_ctr + 1;
    if (m_ctr == beat_len(m_pos)) begin
      m_ctr = 0;
      m_pos = (m_pos == SONG_LEN - 1) ? 0 : m_pos + 1;
      push_exp(1'b1);
      return 1'b1;
    end
    m_sqr  = m_sqr - m_sqr / 8;
    m_bass = m_bass - m_bass / 4;
    push_exp(1'b0);
    return 1'b0;
  endfunction

  function void model_apply(logic [1:0] d);
    if (d[1]) m_sqr = 63;
    if (d[0]) m_bass = 63;
    push_exp(1'b0);
  endfunction

  task automatic pulse_tick();
    @(posedge clk); #1 tick_i = 1'b1;
    @(posedge clk); #1 tick_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rom_if.rom_req_o === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic drive_ack(logic [1:0] d);
    @(posedge clk); #1 rom_if.rom_ack_i = 1'b1; rom_if.rom_data_i = d;
    @(posedge clk); #1 rom_if.rom_ack_i = 1'b0; rom_if.rom_data_i = 2'b00;
    @(negedge clk);
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1 restart_i = 1'b1;
    @(posedge clk); #1 restart_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_reset();
    e = sb.pop_front();
    n_vec++;
    if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o} !== e) begin
      n_err++;
      $display("FAIL reset_state: got pos=%0d sqr=%0d bass=%0d beat=%b, expected pos=%0d sqr=%0d bass=%0d beat=%b",
               songpos_o, sqr_vol_o, bass_vol_o, beat_o, e.pos, e.sqr, e.bass, e.beat);
    end
    n_vec++;
    if ({rom_if.rom_req_o, overrun_o} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags: got req=%b overrun=%b, expected 0 0", rom_if.rom_req_o, overrun_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_first_beat();
    exp_t e;
    bit   ok;
    run_i = 1'b1;
    for (int i = 0; i < TPB; i++) begin
      pulse_tick();
      void'(model_tick());
      e = sb.pop_front();
      n_vec++;
      if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o} !== e) begin
        n_err++;
        $display("FAIL first_beat_tick%0d: got pos=%0d sqr=%0d bass=%0d beat=%b, expected pos=%0d sqr=%0d bass=%0d beat=%b",
                 i, songpos_o, sqr_vol_o, bass_vol_o, beat_o, e.pos, e.sqr, e.bass, e.beat);
      end
    end
    n_vec++;
    if ({rom_if.rom_req_o, rom_if.rom_addr_o} !== {1'b1, 9'd0}) begin
      n_err++;
      $display("FAIL first_beat_req: got req=%b addr=%0d, expected req=1 addr=0", rom_if.rom_req_o, rom_if.rom_addr_o);
    end
    @(negedge clk);
    n_vec++;
    if ({beat_o, rom_if.rom_req_o} !== 2'b01) begin
      n_err++;
      $display("FAIL first_beat_hold: got beat=%b req=%b, expected beat=0 req=1", beat_o, rom_if.rom_req_o);
    end
    drive_ack(2'b11);
    model_apply(2'b11);
    e = sb.pop_front();
    n_vec++;
    if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o, rom_if.rom_req_o} !== {e, 1'b0}) begin
      n_err++;
      $display("FAIL first_beat_apply: got pos=%0d sqr=%0d bass=%0d req=%b, expected pos=%0d sqr=%0d bass=%0d req=0",
               songpos_o, sqr_vol_o, bass_vol_o, rom_if.rom_req_o, e.pos, e.sqr, e.bass);
    end
    ok = 1'b1;
  endtask

  task automatic test_decay();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      pulse_tick();
      void'(model_tick());
      e = sb.pop_front();
      n_vec++;
      if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o} !== e) begin
        n_err++;
        $display("FAIL decay%0d: got sqr=%0d bass=%0d, expected sqr=%0d bass=%0d", i, sqr_vol_o, bass_vol_o, e.sqr, e.bass);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] pats [3] = '{2'b10, 2'b01, 2'b00};
    exp_t e;
    bit   beat, ok;
    foreach (pats[k]) begin
      beat = 1'b0;
      for (int t = 0; t < 10 && !beat; t++) begin
        pulse_tick();
        beat = model_tick();
        e = sb.pop_front();
        n_vec++;
        if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o} !== e) begin
          n_err++;
          $display("FAIL b2b_tick%0d_%0d: got pos=%0d sqr=%0d bass=%0d beat=%b, expected pos=%0d sqr=%0d bass=%0d beat=%b",
                   k, t, songpos_o, sqr_vol_o, bass_vol_o, beat_o, e.pos, e.sqr, e.bass, e.beat);
        end
      end
      wait_req(ok);
      n_vec++;
      if (!ok || rom_if.rom_addr_o !== POS_W'(m_pos)) begin
        n_err++;
        $display("FAIL b2b_req%0d: got req_seen=%b addr=%0d, expected req_seen=1 addr=%0d", k, ok, rom_if.rom_addr_o, m_pos);
      end
      drive_ack(pats[k]);
      model_apply(pats[k]);
      e = sb.pop_front();
      n_vec++;
      if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o} !== e) begin
        n_err++;
        $display("FAIL b2b_apply%0d: got sqr=%0d bass=%0d, expected sqr=%0d bass=%0d", k, sqr_vol_o, bass_vol_o, e.sqr, e.bass);
      end
    end
  endtask

  task automatic test_run_gate();
    exp_t e;
    run_i = 1'b0;
    repeat (8) pulse_tick();
    push_exp(1'b0);
    e = sb.pop_front();
    n_vec++;
    if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o, rom_if.rom_req_o} !== {e, 1'b0}) begin
      n_err++;
      $display("FAIL run_gate: got pos=%0d sqr=%0d bass=%0d req=%b, expected pos=%0d sqr=%0d bass=%0d req=0",
               songpos_o, sqr_vol_o, bass_vol_o, rom_if.rom_req_o, e.pos, e.sqr, e.bass);
    end
    run_i = 1'b1;
  endtask

  task automatic test_wrap();
    exp_t e;
    bit   ok;
    pulse_restart();
    model_reset();
    void'(sb.pop_front());
    repeat (TPB) begin
      pulse_tick();
      void'(model_tick());
    end
    e = sb[$];
    sb.delete();
    n_vec++;
    if ({songpos_o, beat_o} !== {e.pos, e.beat}) begin
      n_err++;
      $display("FAIL wrap: got pos=%0d beat=%b, expected pos=%0d beat=%b", songpos_o, beat_o, e.pos, e.beat);
    end
    wait_req(ok);
    drive_ack(2'b00);
    model_apply(2'b00);
    void'(sb.pop_front());
  endtask

  task automatic test_overrun();
    exp_t e;
    bit   ok;
    repeat (TPB) begin
      pulse_tick();
      void'(model_tick());
    end
    sb.delete();
    wait_req(ok);
    pulse_tick();
    n_vec++;
    if ({overrun_o, rom_if.rom_req_o} !== 2'b01) begin
      n_err++;
      $display("FAIL overrun_first_tick: got overrun=%b req=%b, expected overrun=0 req=1", overrun_o, rom_if.rom_req_o);
    end
    pulse_tick();
    n_vec++;
    if (overrun_o !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_second_tick: got overrun=%b, expected 1", overrun_o);
    end
    drive_ack(2'b01);
    model_apply(2'b01);
    e = sb.pop_front();
    n_vec++;
    if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o} !== e) begin
      n_err++;
      $display("FAIL overrun_apply: got sqr=%0d bass=%0d, expected sqr=%0d bass=%0d", sqr_vol_o, bass_vol_o, e.sqr, e.bass);
    end
    repeat (2) @(negedge clk);
    void'(model_tick());
    e = sb.pop_front();
    n_vec++;
    if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o} !== e) begin
      n_err++;
      $display("FAIL pending_tick: got pos=%0d sqr=%0d bass=%0d, expected pos=%0d sqr=%0d bass=%0d",
               songpos_o, sqr_vol_o, bass_vol_o, e.pos, e.sqr, e.bass);
    end
    for (int t = 0; t < TPB - 1; t++) begin
      pulse_tick();
      void'(model_tick());
    end
    e = sb[$];
    sb.delete();
    n_vec++;
    if ({songpos_o, beat_o, overrun_o} !== {e.pos, e.beat, 1'b1}) begin
      n_err++;
      $display("FAIL overrun_sticky: got pos=%0d beat=%b overrun=%b, expected pos=%0d beat=%b overrun=1",
               songpos_o, beat_o, overrun_o, e.pos, e.beat);
    end
  endtask

  task automatic test_restart();
    exp_t e;
    bit   ok;
    wait_req(ok);
    @(posedge clk); #1 restart_i = 1'b1; tick_i = 1'b1; rom_if.rom_ack_i = 1'b1; rom_if.rom_data_i = 2'b11;
    @(posedge clk); #1 restart_i = 1'b0; tick_i = 1'b0;
    @(negedge clk);
    model_reset();
    e = sb.pop_front();
    n_vec++;
    if ({songpos_o, sqr_vol_o, bass_vol_o, beat_o, rom_if.rom_req_o, overrun_o} !== {e, 2'b00}) begin
      n_err++;
      $display("FAIL restart: got pos=%0d sqr=%0d bass=%0d req=%b overrun=%b, expected pos=%0d sqr=0 bass=0 req=0 overrun=0",
               songpos_o, sqr_vol_o, bass_vol_o, rom_if.rom_req_o, overrun_o, e.pos);
    end
    @(posedge clk); #1 rom_if.rom_ack_i = 1'b0; rom_if.rom_data_i = 2'b00;
    @(negedge clk);
    n_vec++;
    if ({sqr_vol_o, bass_vol_o, rom_if.rom_req_o} !== 13'd0) begin
      n_err++;
      $display("FAIL late_ack: got sqr=%0d bass=%0d req=%b, expected 0 0 0", sqr_vol_o, bass_vol_o, rom_if.rom_req_o);
    end
    for (int t = 0; t < TPB; t++) begin
      pulse_tick();
      void'(model_tick());
      e = sb.pop_front();
      n_vec++;
      if ({songpos_o, beat_o} !== {e.pos, e.beat}) begin
        n_err++;
        $display("FAIL restart_count%0d: got pos=%0d beat=%b, expected pos=%0d beat=%b", t, songpos_o, beat_o, e.pos, e.beat);
      end
    end
    wait_req(ok);
    drive_ack(2'b00);
  endtask

  task automatic test_intervals();
    int  iq[$];
    int  cnt, want, pos;
    bit  ok;
    pulse_restart();
    pos = SONG_LEN - 1;
    for (int b = 0; b < 5; b++) begin
      iq.push_back(beat_len(pos));
      pos = (pos == SONG_LEN - 1) ? 0 : pos + 1;
      cnt = 0;
      for (int t = 0; t < 20; t++) begin
        pulse_tick();
        cnt++;
        if (beat_o === 1'b1) break;
      end
      want = iq.pop_front();
      n_vec++;
      if (cnt !== want || songpos_o !== POS_W'(pos)) begin
        n_err++;
        $display("FAIL interval%0d: got %0d ticks to pos %0d, expected %0d ticks to pos %0d", b, cnt, songpos_o, want, pos);
      end
      wait_req(ok);
      drive_ack(2'b00);
    end
  endtask

  initial begin
    rom_if.rom_ack_i  = 1'b0;
    rom_if.rom_data_i = 2'b00;
    test_reset();
    test_first_beat();
    test_decay();
    test_back_to_back();
    test_run_gate();
    test_wrap();
    test_overrun();
    test_restart();
    test_intervals();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
